// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the MIPS core.
// The next-PC logic uses this package too, for the exception handler vector.
package mips_cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL        = 1;
  localparam int SR_IE         = 0;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 signal bundle.
// The pipeline uses the master modport. CP0 uses the slave modport.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request, EPC capture.
// Priority at each clock edge: exception entry, then eret, then mtc0.
module cp0
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2016
) (
  input logic   clk,
  input logic   reset,
  cp0_if.slave  bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd_q;
  logic [5:0]  ip;
  logic [4:0]  exc_q;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_aligned;
  logic [31:0] epc_entry;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_pc;

  assign int_pend   = (|(bus.HWInt & im)) & ie & ~exl;
  assign exc_pend   = (bus.ExcCode != EXC_INT) & ~exl;
  assign bus.IntReq = int_pend | exc_pend;

  // A victim in a delay slot resumes at its branch.
  assign pc_aligned = {bus.PC[31:2], 2'b00};
  assign epc_entry  = bus.BD ? (pc_aligned - 32'd4) : pc_aligned;
  assign unused_pc  = ^bus.PC[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      bd_q  <= 1'b0;
      ip    <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip <= bus.HWInt;
      if (bus.IntReq) begin
        exl   <= 1'b1;
        bd_q  <= bus.BD;
        exc_q <= int_pend ? EXC_INT : bus.ExcCode;
        epc_q <= epc_entry;
      end else if (bus.EXLClr) begin
        exl <= 1'b0;
      end else if (bus.We) begin
        if (bus.A2 == REG_SR) begin
          im  <= bus.DIn[SR_IM_LSB +: 6];
          exl <= bus.DIn[SR_EXL];
          ie  <= bus.DIn[SR_IE];
        end else if (bus.A2 == REG_EPC) begin
          epc_q <= {bus.DIn[31:2], 2'b00};
        end
      end
    end
  end

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {bd_q, 15'b0, ip, 3'b0, exc_q, 2'b00};
  assign bus.EPC    = epc_q;

  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      REG_SR:    bus.DOut = sr_word;
      REG_CAUSE: bus.DOut = cause_word;
      REG_EPC:   bus.DOut = epc_q;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = '0;
    endcase
  end

endmodule
